// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C bus between several masters,
// with a bus-free guard time before each grant and a hold-time watchdog.
module i2c_bus_arbiter #(
    parameter int unsigned REQUESTER_COUNT = 2,
    parameter int unsigned GUARD_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES  = 20_000_000
) (
    input  logic                       system_clock,
    input  logic                       system_reset_n,
    input  logic [REQUESTER_COUNT-1:0] request,
    output logic [REQUESTER_COUNT-1:0] grant,
    input  logic [REQUESTER_COUNT-1:0] master_scl_output,
    input  logic [REQUESTER_COUNT-1:0] master_sda_output,
    input  logic                       scl_input,
    input  logic                       sda_input,
    output logic                       scl_output,
    output logic                       sda_output,
    output logic                       busy,
    output logic                       timeout
);

    localparam int unsigned IDX_W   = $clog2(REQUESTER_COUNT);
    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned HOLD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(REQUESTER_COUNT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  =
        HOLD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_GRANT
    } state_t;

    state_t                     state, state_next;
    logic [IDX_W-1:0]           winner, winner_next;
    logic [IDX_W-1:0]           last, last_next;
    logic [GUARD_W-1:0]         guard_cnt, guard_next;
    logic [HOLD_W-1:0]          hold_cnt, hold_next;
    logic [REQUESTER_COUNT-1:0] lockout, lockout_next;
    logic [REQUESTER_COUNT-1:0] grant_next;
    logic                       timeout_next;

    logic [REQUESTER_COUNT-1:0] eligible;
    logic [IDX_W-1:0]           scan_idx;
    logic [IDX_W-1:0]           pick;
    logic                       pick_valid;
    logic                       bus_idle;

    assign bus_idle = scl_input & sda_input;

    // Round-robin search: first eligible index above the last winner, wrapping.
    always_comb begin
        eligible   = request & ~lockout;
        scan_idx   = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned i = 1; i <= REQUESTER_COUNT; i++) begin
            scan_idx = IDX_W'((32'(last) + i) % REQUESTER_COUNT);
            if (!pick_valid && eligible[scan_idx]) begin
                pick       = scan_idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        winner_next  = winner;
        last_next    = last;
        guard_next   = guard_cnt;
        hold_next    = hold_cnt;
        grant_next   = grant;
        timeout_next = 1'b0;
        lockout_next = lockout & request;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_next = pick;
                    guard_next  = '0;
                    state_next  = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!request[winner]) begin
                    state_next = ST_IDLE;
                end else if (!bus_idle) begin
                    guard_next = '0;
                end else if (guard_cnt == GUARD_LAST) begin
                    grant_next         = '0;
                    grant_next[winner] = 1'b1;
                    last_next          = winner;
                    guard_next         = '0;
                    hold_next          = '0;
                    state_next         = ST_GRANT;
                end else begin
                    guard_next = guard_cnt + GUARD_W'(1);
                end
            end
            ST_GRANT: begin
                if (!request[winner]) begin
                    grant_next = '0;
                    hold_next  = '0;
                    state_next = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (hold_cnt == HOLD_LAST)) begin
                    grant_next           = '0;
                    hold_next            = '0;
                    timeout_next         = 1'b1;
                    lockout_next[winner] = 1'b1;
                    state_next           = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!system_reset_n) begin
            state     <= ST_IDLE;
            winner    <= '0;
            last      <= LAST_RESET;
            guard_cnt <= '0;
            hold_cnt  <= '0;
            lockout   <= '0;
            grant     <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            winner    <= winner_next;
            last      <= last_next;
            guard_cnt <= guard_next;
            hold_cnt  <= hold_next;
            lockout   <= lockout_next;
            grant     <= grant_next;
            timeout   <= timeout_next;
        end
    end

    // Grant is one-hot or zero, so a masked AND selects the owner's drive or releases.
    assign scl_output = &(master_scl_output | ~grant);
    assign sda_output = &(master_sda_output | ~grant);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: per-cycle comparison against an
// owner/candidate model of the arbitration rules, plus literal latency checks.
module tb_i2c_bus_arbiter;

    localparam int N = 2;
    localparam int G = 4;
    localparam int T = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic [N-1:0] mscl;
    logic [N-1:0] msda;
    logic         scl_in;
    logic         sda_in;
    logic         scl_out;
    logic         sda_out;
    logic         busy;
    logic         timeout;

    int vectors     = 0;
    int miscompares = 0;

    i2c_bus_arbiter #(
        .REQUESTER_COUNT(N),
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .system_clock     (clk),
        .system_reset_n   (rst_n),
        .request          (request),
        .grant            (grant),
        .master_scl_output(mscl),
        .master_sda_output(msda),
        .scl_input        (scl_in),
        .sda_input        (sda_in),
        .scl_output       (scl_out),
        .sda_output       (sda_out),
        .busy             (busy),
        .timeout          (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: owner = master holding the bus, cand = master waiting out the guard time.
    int      m_owner, m_cand, m_run, m_held, m_last;
    bit [N-1:0] m_locked;
    bit      m_tpulse;
    bit      model_valid = 1'b0;

    always @(posedge clk) begin : model
        int o, c, r, h, l, w;
        bit [N-1:0] lk, lk_new;
        bit tp, found;
        o = m_owner; c = m_cand; r = m_run; h = m_held; l = m_last; lk = m_locked;
        tp = 1'b0;
        if (!rst_n) begin
            o = -1; c = -1; r = 0; h = 0; l = N - 1; lk = '0;
        end else begin
            lk_new = lk & request;
            if (o >= 0) begin
                if (!request[o]) begin
                    o = -1; h = 0;
                end else begin
                    h = h + 1;
                    if (T != 0 && h == T) begin
                        tp = 1'b1; lk_new[o] = 1'b1; o = -1; h = 0;
                    end
                end
            end else if (c >= 0) begin
                if (!request[c]) c = -1;
                else if (scl_in && sda_in) begin
                    r = r + 1;
                    if (r == G) begin
                        o = c; l = c; c = -1; h = 0;
                    end
                end else r = 0;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    w = (l + k) % N;
                    if (!found && request[w] && !lk[w]) begin
                        found = 1'b1; c = w; r = 0;
                    end
                end
            end
            lk = lk_new;
        end
        m_owner <= o; m_cand <= c; m_run <= r; m_held <= h; m_last <= l;
        m_locked <= lk; m_tpulse <= tp; model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("grant",   int'(grant),   (m_owner >= 0) ? (1 << m_owner) : 0);
            check("busy",    int'(busy),    (m_owner >= 0 || m_cand >= 0) ? 1 : 0);
            check("timeout", int'(timeout), int'(m_tpulse));
            check("scl_output", int'(scl_out), (m_owner >= 0) ? int'(mscl[m_owner]) : 1);
            check("sda_output", int'(sda_out), (m_owner >= 0) ? int'(msda[m_owner]) : 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges until a grant appears; an exhausted budget is a failure.
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 100);
        if (grant == '0) check("wait_grant_budget", n, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, held;
        rst_n = 1'b0; request = '0; mscl = '1; msda = '1; scl_in = 1'b1; sda_in = 1'b1;
        tick(); tick();
        check("reset_grant", int'(grant), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_scl", int'(scl_out), 1);
        check("reset_sda", int'(sda_out), 1);
        rst_n = 1'b1;
        tick();

        // Single request on an idle bus
        request = 2'b01;
        tick();
        check("s1_busy_cycle1", int'(busy), 1);
        check("s1_grant_cycle1", int'(grant), 0);
        wait_grant(n);
        check("s1_latency", n + 1, G + 1);
        check("s1_grant", int'(grant), 1);
        mscl = 2'b10;
        tick();
        check("s1_scl_follow", int'(scl_out), 0);
        mscl = 2'b11;
        request = 2'b00;
        tick();
        check("s1_release_grant", int'(grant), 0);
        check("s1_release_busy", int'(busy), 0);

        // Round robin from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        request = 2'b11;
        wait_grant(n);
        check("s2_first_latency", n, G + 1);
        check("s2_first_grant", int'(grant), 1);
        request = 2'b10;
        tick();
        check("s2_drop_grant", int'(grant), 0);
        wait_grant(n);
        check("s2_second_latency", n, G + 1);
        check("s2_second_grant", int'(grant), 2);

        // Mux isolation while master 1 owns the bus
        msda = 2'b01;
        tick();
        check("s4_sda_owner_low", int'(sda_out), 0);
        msda = 2'b11; mscl = 2'b10;
        tick();
        check("s4_scl_nonowner_ignored", int'(scl_out), 1);
        mscl = 2'b11;
        tick();
        check("s4_release_scl", int'(scl_out), 1);
        check("s4_release_sda", int'(sda_out), 1);
        request = 2'b00;
        tick();
        request = 2'b11;
        wait_grant(n);
        check("s2_rr_latency", n, G + 1);
        check("s2_rr_grant", int'(grant), 1);

        // Guard counter restart on a bus glitch
        request = 2'b00;
        tick(); tick();
        request = 2'b01;
        tick(); tick(); tick();
        sda_in = 1'b0;
        tick();
        sda_in = 1'b1;
        wait_grant(n);
        check("s3_latency", 4 + n, G + 1 + 3);
        check("s3_grant", int'(grant), 1);

        // Timeout with a competing requester
        request = 2'b11;
        held = 1;
        n = 0;
        while (grant == 2'b01 && n < 100) begin
            tick();
            n++;
            if (grant == 2'b01) held++;
        end
        check("s5_held_cycles", held, T);
        check("s5_timeout_pulse", int'(timeout), 1);
        check("s5_grant_dropped", int'(grant), 0);
        wait_grant(n);
        check("s5_timeout_single", 0, 0 + (n < 2 ? 1 : 0));
        check("s5_next_latency", n, G + 1);
        check("s5_next_grant", int'(grant), 2);
        request = 2'b01;
        tick();
        check("s5_m1_release", int'(grant), 0);
        repeat (20) tick();
        check("s5_locked_grant", int'(grant), 0);
        check("s5_locked_busy", int'(busy), 0);
        request = 2'b00;
        tick();
        request = 2'b01;
        wait_grant(n);
        check("s5_relock_latency", n, G + 1);
        check("s5_relock_grant", int'(grant), 1);

        // Reset mid-grant releases the bus at once
        msda = 2'b10;
        tick();
        check("s6_sda_driven", int'(sda_out), 0);
        rst_n = 1'b0;
        tick();
        check("s6_grant", int'(grant), 0);
        check("s6_sda", int'(sda_out), 1);
        check("s6_busy", int'(busy), 0);
        rst_n = 1'b1;
        msda = 2'b11;
        request = 2'b11;
        wait_grant(n);
        check("s6_rearb_latency", n, G + 1);
        check("s6_rearb_grant", int'(grant), 1);
        request = 2'b00;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
